// File: rtl/pic_ctrl_pkg.sv
// Shared constants for the programmable interrupt controller.
package pic_ctrl_pkg;

    localparam logic        PIC_CFG_MASK    = 1'b0;
    localparam logic        PIC_CFG_MODE    = 1'b1;
    localparam int unsigned PIC_NUM_IRQ_DEF = 8;

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index-first priority encoder; index 0 wins.
module pic_prio_enc #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] i_req,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pic_ctrl.sv
// Registered programmable interrupt controller: mask/mode config, latched
// pending, ack/eoi handshake and in-service tracking for strict preemption.
module pic_ctrl
    import pic_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ = PIC_NUM_IRQ_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               cfg_we,
    input  logic               cfg_addr,
    input  logic [NUM_IRQ-1:0] cfg_wdata,
    output logic [NUM_IRQ-1:0] cfg_rdata,
    output logic               INT,
    output logic [ID_W-1:0]    INT_NUM,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_mode;
    logic [NUM_IRQ-1:0] r_in_service;
    logic               r_int;
    logic [ID_W-1:0]    r_int_num;

    logic               w_cand_valid;
    logic [ID_W-1:0]    w_cand_idx;
    logic               w_lvl_valid;
    logic [ID_W-1:0]    w_lvl_idx;
    logic               w_ack;
    logic [NUM_IRQ-1:0] w_ack_vec;
    logic [NUM_IRQ-1:0] w_eoi_vec;
    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_pending_nxt;
    logic [NUM_IRQ-1:0] w_in_service_nxt;
    logic               w_int_nxt;

    pic_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_cand_enc (
        .i_req   (r_pending & r_mask),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    pic_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_lvl_enc (
        .i_req   (r_in_service),
        .o_valid (w_lvl_valid),
        .o_idx   (w_lvl_idx)
    );

    // An ack only counts against a request the core can actually see.
    assign w_ack     = int_ack & r_int;
    assign w_ack_vec = w_ack ? (NUM_IRQ'(1) << r_int_num) : '0;
    assign w_eoi_vec = (int_eoi & w_lvl_valid) ? (NUM_IRQ'(1) << w_lvl_idx) : '0;

    // EOI retires the old level before the ack marks the new one.
    assign w_in_service_nxt = (r_in_service & ~w_eoi_vec) | w_ack_vec;

    // A fresh edge beats a simultaneous ack clear.
    assign w_edge        = IRQ & ~r_irq_q;
    assign w_pending_nxt = (r_mode & ((r_pending & ~w_ack_vec) | w_edge)) | (~r_mode & IRQ);

    assign w_int_nxt = w_cand_valid & (~w_lvl_valid | (w_cand_idx < w_lvl_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_q      <= '0;
            r_pending    <= '0;
            r_mask       <= '1;
            r_mode       <= '0;
            r_in_service <= '0;
            r_int        <= 1'b0;
            r_int_num    <= '0;
        end else begin
            r_irq_q      <= IRQ;
            r_pending    <= w_pending_nxt;
            r_in_service <= w_in_service_nxt;
            r_int        <= w_int_nxt;
            r_int_num    <= w_int_nxt ? w_cand_idx : '0;
            if (cfg_we) begin
                if (cfg_addr == PIC_CFG_MODE) begin
                    r_mode <= cfg_wdata;
                end else begin
                    r_mask <= cfg_wdata;
                end
            end
        end
    end

    always_comb begin
        cfg_rdata = r_mask;
        if (cfg_addr == PIC_CFG_MODE) begin
            cfg_rdata = r_mode;
        end
    end

    assign INT     = r_int;
    assign INT_NUM = r_int_num;
    assign pending = r_pending;

endmodule

// File: tb/tb_pic_ctrl.sv
// Bench for pic_ctrl: directed scenarios plus a randomized run against a cycle model.
module tb_pic_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] IRQ;
    logic       cfg_we;
    logic       cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       INT;
    logic [2:0] INT_NUM;
    logic       int_ack;
    logic       int_eoi;
    logic [7:0] pending;

    int n_checks;
    int n_pass;

    pic_ctrl #(.NUM_IRQ(8), .ID_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .IRQ       (IRQ),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .INT       (INT),
        .INT_NUM   (INT_NUM),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_irq_q, m_pend, m_isv, m_mask, m_mode;
    logic       m_int;
    logic [2:0] m_num;

    task automatic model_reset();
        m_irq_q = '0; m_pend = '0; m_isv = '0;
        m_mask = 8'hFF; m_mode = 8'h00; m_int = 1'b0; m_num = '0;
    endtask

    task automatic model_step();
        int cand, lvl;
        logic [7:0] np, ni;
        cand = 8;
        lvl  = 8;
        for (int i = 7; i >= 0; i--) begin
            if (m_pend[i] && m_mask[i]) cand = i;
            if (m_isv[i]) lvl = i;
        end
        ni = m_isv;
        if (int_eoi && lvl < 8) ni[lvl] = 1'b0;
        if (int_ack && m_int) ni[m_num] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (!m_mode[i]) np[i] = IRQ[i];
            else np[i] = (m_pend[i] && !(int_ack && m_int && m_num == 3'(i))) || (IRQ[i] && !m_irq_q[i]);
        end
        if (cfg_we) begin
            if (cfg_addr) m_mode = cfg_wdata;
            else m_mask = cfg_wdata;
        end
        m_int   = (cand < lvl);
        m_num   = m_int ? 3'(cand) : 3'd0;
        m_pend  = np;
        m_isv   = ni;
        m_irq_q = IRQ;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_checks++; if (INT !== 1'b0) $display("FAIL reset_int: got %0b want 0", INT); else n_pass++;
        n_checks++; if (INT_NUM !== 3'd0) $display("FAIL reset_num: got %0d want 0", INT_NUM); else n_pass++;
        n_checks++; if (pending !== 8'h00) $display("FAIL reset_pending: got %h want 00", pending); else n_pass++;
        n_checks++; if (cfg_rdata !== 8'hFF) $display("FAIL reset_mask: got %h want ff", cfg_rdata); else n_pass++;
        cfg_addr = 1'b1; #1;
        n_checks++; if (cfg_rdata !== 8'h00) $display("FAIL reset_mode: got %h want 00", cfg_rdata); else n_pass++;
        cfg_addr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_level();
        IRQ = 8'h20; cyc();
        n_checks++; if (pending !== 8'h20) $display("FAIL level_pending: got %h want 20", pending); else n_pass++;
        n_checks++; if (INT !== 1'b0) $display("FAIL level_int_early: got %0b want 0", INT); else n_pass++;
        cyc();
        n_checks++; if (INT !== 1'b1 || INT_NUM !== 3'd5) $display("FAIL level_int: got %0b/%0d want 1/5", INT, INT_NUM); else n_pass++;
        IRQ = 8'h00; cyc(); cyc();
        n_checks++; if (INT !== 1'b0 || INT_NUM !== 3'd0) $display("FAIL level_drop: got %0b/%0d want 0/0", INT, INT_NUM); else n_pass++;
    endtask

    task automatic test_edge();
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 8'hFF; cyc();
        cfg_we = 1'b0; #1;
        n_checks++; if (cfg_rdata !== 8'hFF) $display("FAIL edge_mode_rd: got %h want ff", cfg_rdata); else n_pass++;
        cfg_addr = 1'b0;
        IRQ = 8'h08; cyc();
        IRQ = 8'h00; cyc();
        n_checks++; if (INT !== 1'b1 || INT_NUM !== 3'd3) $display("FAIL edge_int: got %0b/%0d want 1/3", INT, INT_NUM); else n_pass++;
        cyc(); cyc();
        n_checks++; if (INT !== 1'b1 || INT_NUM !== 3'd3 || pending !== 8'h08) $display("FAIL edge_latched: got %0b/%0d/%h want 1/3/08", INT, INT_NUM, pending); else n_pass++;
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        n_checks++; if (pending !== 8'h00) $display("FAIL edge_ack_pending: got %h want 00", pending); else n_pass++;
        n_checks++; if (dut.r_in_service !== 8'h08) $display("FAIL edge_isv: got %h want 08", dut.r_in_service); else n_pass++;
        cyc();
        n_checks++; if (INT !== 1'b0) $display("FAIL edge_int_drop: got %0b want 0", INT); else n_pass++;
    endtask

    task automatic test_preempt();
        IRQ = 8'h40; cyc();
        IRQ = 8'h00; cyc(); cyc();
        n_checks++; if (INT !== 1'b0 || pending !== 8'h40) $display("FAIL pre_blocked: got %0b/%h want 0/40", INT, pending); else n_pass++;
        IRQ = 8'h02; cyc();
        IRQ = 8'h00; cyc();
        n_checks++; if (INT !== 1'b1 || INT_NUM !== 3'd1) $display("FAIL pre_int: got %0b/%0d want 1/1", INT, INT_NUM); else n_pass++;
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        n_checks++; if (dut.r_in_service !== 8'h0A) $display("FAIL pre_isv_0a: got %h want 0a", dut.r_in_service); else n_pass++;
        cyc();
        n_checks++; if (INT !== 1'b0) $display("FAIL pre_int_drop: got %0b want 0", INT); else n_pass++;
        int_eoi = 1'b1; cyc(); int_eoi = 1'b0;
        n_checks++; if (dut.r_in_service !== 8'h08) $display("FAIL pre_isv_08: got %h want 08", dut.r_in_service); else n_pass++;
        int_eoi = 1'b1; cyc(); int_eoi = 1'b0;
        n_checks++; if (dut.r_in_service !== 8'h00) $display("FAIL pre_isv_00: got %h want 00", dut.r_in_service); else n_pass++;
        cyc();
        n_checks++; if (INT !== 1'b1 || INT_NUM !== 3'd6) $display("FAIL pre_deliver6: got %0b/%0d want 1/6", INT, INT_NUM); else n_pass++;
        int_ack = 1'b1; cyc(); int_ack = 1'b0;
        int_eoi = 1'b1; cyc(); int_eoi = 1'b0;
        cyc();
        n_checks++; if (INT !== 1'b0 || dut.r_in_service !== 8'h00) $display("FAIL pre_clean: got %0b/%h want 0/00", INT, dut.r_in_service); else n_pass++;
    endtask

    task automatic test_mask();
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 8'h00; cyc();
        cfg_addr = 1'b0; cfg_wdata = 8'hFB; IRQ = 8'h04; cyc();
        cfg_we = 1'b0; cyc(); cyc();
        n_checks++; if (INT !== 1'b0 || pending !== 8'h04) $display("FAIL mask_block: got %0b/%h want 0/04", INT, pending); else n_pass++;
        n_checks++; if (cfg_rdata !== 8'hFB) $display("FAIL mask_rd: got %h want fb", cfg_rdata); else n_pass++;
        cfg_we = 1'b1; cfg_wdata = 8'hFF; cyc();
        cfg_we = 1'b0; cyc();
        n_checks++; if (INT !== 1'b1 || INT_NUM !== 3'd2) $display("FAIL mask_unmask: got %0b/%0d want 1/2", INT, INT_NUM); else n_pass++;
        IRQ = 8'h00; cyc(); cyc();
        n_checks++; if (INT !== 1'b0) $display("FAIL mask_drop: got %0b want 0", INT); else n_pass++;
    endtask

    task automatic test_edge_ack_collision();
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 8'hFF; cyc();
        cfg_we = 1'b0; cfg_addr = 1'b0;
        IRQ = 8'h10; cyc();
        IRQ = 8'h00; cyc();
        n_checks++; if (INT !== 1'b1 || INT_NUM !== 3'd4) $display("FAIL coll_int: got %0b/%0d want 1/4", INT, INT_NUM); else n_pass++;
        IRQ = 8'h10; int_ack = 1'b1; cyc();
        IRQ = 8'h00; int_ack = 1'b0;
        n_checks++; if (pending !== 8'h10) $display("FAIL coll_pending: got %h want 10", pending); else n_pass++;
        n_checks++; if (dut.r_in_service !== 8'h10) $display("FAIL coll_isv: got %h want 10", dut.r_in_service); else n_pass++;
    endtask

    task automatic test_reset_mid();
        n_checks++; if (INT !== 1'b1) $display("FAIL rstmid_pre_int: got %0b want 1", INT); else n_pass++;
        #2 rst = 1'b1; #1;
        model_reset();
        n_checks++; if (INT !== 1'b0 || INT_NUM !== 3'd0) $display("FAIL rstmid_int: got %0b/%0d want 0/0", INT, INT_NUM); else n_pass++;
        n_checks++; if (pending !== 8'h00) $display("FAIL rstmid_pending: got %h want 00", pending); else n_pass++;
        n_checks++; if (dut.r_in_service !== 8'h00) $display("FAIL rstmid_isv: got %h want 00", dut.r_in_service); else n_pass++;
        n_checks++; if (cfg_rdata !== 8'hFF) $display("FAIL rstmid_mask: got %h want ff", cfg_rdata); else n_pass++;
        cfg_addr = 1'b1; #1;
        n_checks++; if (cfg_rdata !== 8'h00) $display("FAIL rstmid_mode: got %h want 00", cfg_rdata); else n_pass++;
        cfg_addr = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic last_ack;
        last_ack = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int k = 0; k < 600; k++) begin
            IRQ       = 8'($urandom) & 8'($urandom);
            cfg_we    = ($urandom_range(0, 15) == 0);
            cfg_addr  = 1'($urandom_range(0, 1));
            cfg_wdata = cfg_addr ? 8'($urandom) : (8'($urandom) | 8'($urandom));
            int_ack   = m_int && !last_ack && ($urandom_range(0, 1) == 1);
            int_eoi   = ($urandom_range(0, 5) == 0);
            last_ack  = int_ack;
            cyc();
            n_checks++; if (INT !== m_int || INT_NUM !== m_num) $display("FAIL rnd_int[%0d]: got %0b/%0d want %0b/%0d", k, INT, INT_NUM, m_int, m_num); else n_pass++;
            n_checks++; if (pending !== m_pend) $display("FAIL rnd_pending[%0d]: got %h want %h", k, pending, m_pend); else n_pass++;
            n_checks++; if (dut.r_in_service !== m_isv) $display("FAIL rnd_isv[%0d]: got %h want %h", k, dut.r_in_service, m_isv); else n_pass++;
            n_checks++; if (cfg_rdata !== (cfg_addr ? m_mode : m_mask)) $display("FAIL rnd_cfg[%0d]: got %h want %h", k, cfg_rdata, cfg_addr ? m_mode : m_mask); else n_pass++;
        end
        cfg_we = 1'b0; int_ack = 1'b0; int_eoi = 1'b0; IRQ = 8'h00;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; IRQ = '0; cfg_we = 1'b0; cfg_addr = 1'b0;
        cfg_wdata = '0; int_ack = 1'b0; int_eoi = 1'b0;
        n_checks = 0; n_pass = 0;
        model_reset();
        test_reset();
        test_level();
        test_edge();
        test_preempt();
        test_mask();
        test_edge_ack_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
